// File: rtl/apple_pkg.sv
// apple_pkg: shared types and constants for the apple manager
package apple_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SWEEP} state_e;
  typedef logic [7:0] loc_t;
  localparam loc_t APPLE_RESET_LOC = 8'h55;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/apple_manager_if.sv
// apple_manager_if: collision/renderer-facing signals of the apple manager
interface apple_if #(
  parameter int NUM_APPLES = 2,
  parameter int COORD_W = 4
);
  logic [NUM_APPLES-1:0] good_collision;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [NUM_APPLES*2*COORD_W-1:0] apple_location;
  logic [NUM_APPLES-1:0] apple_valid;
  logic apple;
  logic busy;
  modport master (output good_collision, x, y, input apple_location, apple_valid, apple, busy);
  modport slave (input good_collision, x, y, output apple_location, apple_valid, apple, busy);
endinterface

// File: rtl/apple_lfsr.sv
// apple_lfsr: free-running Fibonacci LFSR, feedback includes the MSB so a nonzero state never reaches zero
module apple_lfsr
  import apple_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] SEED = W'(LFSR_SEED)
) (
  input  logic system_clk,
  input  logic nreset,
  output logic [W-1:0] value
);
  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS) << (W - 8);
  // shift left every cycle, new LSB is the parity of the tapped bits
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) value <= SEED;
    else value <= {value[W-2:0], ^(value & TAPS)};
endmodule

// File: rtl/apple_manager.sv
// apple_manager: places NUM_APPLES apples on legal cells and publishes them on a divided body tick
module apple_manager
  import apple_pkg::*;
#(
  parameter int NUM_APPLES = 2,
  parameter int MAX_LENGTH = 30,
  parameter int COORD_W = 4,
  parameter int NUM_WALLS = 25,
  parameter int MAX_TRIES = 8,
  parameter int BODY_DIV = 3
) (
  input  logic system_clk,
  input  logic nreset,
  input  logic body_tick,
  input  logic enable_in,
  input  logic [$clog2(MAX_LENGTH+1)-1:0] snake_length,
  input  logic [MAX_LENGTH*COORD_W-1:0] snakeArrayX,
  input  logic [MAX_LENGTH*COORD_W-1:0] snakeArrayY,
  input  logic [NUM_WALLS*2*COORD_W-1:0] wall_locations,
  input  logic [COORD_W-1:0] xmin,
  input  logic [COORD_W-1:0] xmax,
  input  logic [COORD_W-1:0] ymin,
  input  logic [COORD_W-1:0] ymax,
  apple_if.slave bus
);
  localparam int LOC_W = 2 * COORD_W;
  localparam int LW = LOC_W > 8 ? LOC_W : 8;
  localparam int LEN_W = $clog2(MAX_LENGTH + 1);
  localparam int DIV_W = BODY_DIV > 1 ? $clog2(BODY_DIV) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES) + 1;
  localparam int SEL_W = NUM_APPLES > 1 ? $clog2(NUM_APPLES) : 1;
  localparam logic [1:0] IDLE = 2'(S_IDLE), CHECK = 2'(S_CHECK), SWEEP = 2'(S_SWEEP);
  localparam logic [LOC_W-1:0] RST_LOC = {COORD_W'(APPLE_RESET_LOC[7:4]), COORD_W'(APPLE_RESET_LOC[3:0])};
  logic [1:0] state;
  logic [SEL_W-1:0] sel, low;
  logic [LOC_W-1:0] cand;
  logic [COORD_W-1:0] cx, cy;
  logic [TRY_W-1:0] tries;
  logic [NUM_APPLES-1:0] pending, en_mask, clr, shadow_valid, pub_valid;
  logic [NUM_APPLES-1:0][LOC_W-1:0] shadow, pub;
  logic [DIV_W-1:0] div;
  logic [LW-1:0] lfsr;
  logic strobe, cand_ok, done, exhaust, hit;

  apple_lfsr #(.W(LW), .SEED(LW'(LFSR_SEED))) u_lfsr (
    .system_clk(system_clk),
    .nreset(nreset),
    .value(lfsr)
  );

  function automatic logic legal(input logic [LOC_W-1:0] c);
    logic [COORD_W-1:0] lx, ly;
    lx = c[COORD_W-1:0];
    ly = c[LOC_W-1:COORD_W];
    legal = lx >= xmin && lx <= xmax && ly >= ymin && ly <= ymax;
    for (int i = 0; i < MAX_LENGTH; i++)
      if (LEN_W'(i) < snake_length && snakeArrayX[i*COORD_W +: COORD_W] == lx && snakeArrayY[i*COORD_W +: COORD_W] == ly)
        legal = 1'b0;
    for (int i = 0; i < NUM_WALLS; i++)
      if (wall_locations[i*LOC_W +: LOC_W] == c) legal = 1'b0;
    for (int i = 0; i < NUM_APPLES; i++)
      if (SEL_W'(i) != sel && en_mask[i] && shadow_valid[i] && shadow[i] == c) legal = 1'b0;
  endfunction

  assign en_mask = enable_in ? '1 : NUM_APPLES'(1);
  assign cx = cand[COORD_W-1:0];
  assign cy = cand[LOC_W-1:COORD_W];
  assign cand_ok = legal(cand);
  assign done = (state == CHECK || state == SWEEP) && cand_ok;
  assign exhaust = state == SWEEP && !cand_ok && (xmin > xmax || ymin > ymax || (cx >= xmax && cy >= ymax));
  assign clr = (done || exhaust) ? NUM_APPLES'(1) << sel : '0;
  assign bus.busy = state != IDLE || |pending;
  assign bus.apple_location = pub;
  assign bus.apple_valid = pub_valid;
  assign bus.apple = hit;

  // lowest pending slot and renderer hit test
  always_comb begin
    low = '0;
    hit = 1'b0;
    for (int i = NUM_APPLES - 1; i >= 0; i--) low = pending[i] ? SEL_W'(i) : low;
    for (int i = 0; i < NUM_APPLES; i++) hit = hit | (pub_valid[i] && pub[i] == {bus.y, bus.x});
  end

  // request queue: a new pulse wins over the clear of the slot just serviced
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) pending <= '0;
    else pending <= ((pending & ~clr) | bus.good_collision) & en_mask;

  // placement search: random draws, then a raster sweep of the bounds
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      sel <= '0;
      cand <= RST_LOC;
      tries <= '0;
    end else case (state)
      IDLE: if (|pending) begin
        sel <= low;
        cand <= lfsr[LOC_W-1:0];
        tries <= '0;
        state <= CHECK;
      end
      CHECK: if (cand_ok) state <= IDLE;
        else if (tries == TRY_W'(MAX_TRIES - 1)) begin
          cand <= {ymin, xmin};
          state <= SWEEP;
        end else begin
          tries <= tries + 1'b1;
          cand <= lfsr[LOC_W-1:0];
        end
      SWEEP: if (done || exhaust) state <= IDLE;
        else cand <= cx >= xmax ? {cy + COORD_W'(1), xmin} : {cy, cx + COORD_W'(1)};
      default: state <= IDLE;
    endcase

  // shadow positions, updated on commit or exhausted sweep
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) begin
      shadow <= {NUM_APPLES{RST_LOC}};
      shadow_valid <= NUM_APPLES'(1);
    end else if (done) begin
      shadow[sel] <= cand;
      shadow_valid[sel] <= 1'b1;
    end else if (exhaust) shadow_valid[sel] <= 1'b0;

  // body tick divider; strobe fires the cycle after the wrap
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) begin
      div <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= body_tick && div == DIV_W'(BODY_DIV - 1);
      if (body_tick) div <= div == DIV_W'(BODY_DIV - 1) ? '0 : div + 1'b1;
    end

  // published copy of the shadow, gated slots show zero and invalid
  always_ff @(posedge system_clk or negedge nreset)
    if (!nreset) begin
      pub <= {NUM_APPLES{RST_LOC}};
      pub_valid <= NUM_APPLES'(1);
    end else if (strobe) begin
      for (int i = 0; i < NUM_APPLES; i++) pub[i] <= en_mask[i] ? shadow[i] : '0;
      pub_valid <= shadow_valid & en_mask;
    end
endmodule

// File: tb/tb_apple_manager.sv
// tb_apple_manager: directed checks of placement, sweep, exhaustion, gating and reset
module tb_apple_manager;
  logic system_clk = 1'b0;
  logic nreset = 1'b0;
  logic body_tick = 1'b0;
  logic enable_in = 1'b1;
  logic [4:0] snake_length = 5'd1;
  logic [119:0] snake_x = '0;
  logic [119:0] snake_y = '0;
  logic [199:0] walls = '0;
  logic [3:0] xmin = 4'd0, xmax = 4'd15, ymin = 4'd0, ymax = 4'd15;
  int total = 0;
  int bad = 0;
  logic [15:0] loc;

  apple_if #(.NUM_APPLES(2), .COORD_W(4)) bus ();

  apple_manager dut (
    .system_clk(system_clk),
    .nreset(nreset),
    .body_tick(body_tick),
    .enable_in(enable_in),
    .snake_length(snake_length),
    .snakeArrayX(snake_x),
    .snakeArrayY(snake_y),
    .wall_locations(walls),
    .xmin(xmin),
    .xmax(xmax),
    .ymin(ymin),
    .ymax(ymax),
    .bus(bus)
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge system_clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] v);
    bus.good_collision = v;
    tick;
    bus.good_collision = 2'b00;
  endtask

  task automatic publish;
    body_tick = 1'b1;
    repeat (3) tick;
    body_tick = 1'b0;
    tick;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 40) begin
      tick;
      n++;
    end
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic set_seg(input int i, input logic [3:0] sy, input logic [3:0] sx);
    snake_y[i*4 +: 4] = sy;
    snake_x[i*4 +: 4] = sx;
  endtask

  task automatic set_walls(input logic [7:0] w);
    for (int i = 0; i < 25; i++) walls[i*8 +: 8] = w;
  endtask

  task automatic open_grid;
    xmin = 4'd0; xmax = 4'd15; ymin = 4'd0; ymax = 4'd15;
    snake_length = 5'd1;
    set_seg(0, 4'd0, 4'd0);
    set_walls(8'h00);
  endtask

  task automatic crowded(input logic [4:0] len);
    xmin = 4'd2; xmax = 4'd3; ymin = 4'd2; ymax = 4'd3;
    set_seg(0, 4'd2, 4'd2);
    set_seg(1, 4'd2, 4'd3);
    set_seg(2, 4'd3, 4'd3);
    snake_length = len;
    set_walls(8'h32);
  endtask

  initial begin
    bus.good_collision = 2'b00;
    bus.x = 4'd5;
    bus.y = 4'd5;
    open_grid;
    repeat (2) tick;
    nreset = 1'b1;
    tick;
    chk("rst_loc", 32'(bus.apple_location), 32'h5555);
    chk("rst_valid", 32'(bus.apple_valid), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_hit", 32'(bus.apple), 32'h1);
    bus.x = 4'd6;
    #1;
    chk("rst_miss", 32'(bus.apple), 32'h0);

    pulse(2'b01);
    chk("single_pending", 32'(bus.busy), 32'h1);
    tick;
    chk("single_check", 32'(bus.busy), 32'h1);
    tick;
    chk("single_commit", 32'(bus.busy), 32'h0);
    body_tick = 1'b1;
    repeat (3) tick;
    body_tick = 1'b0;
    chk("pub_not_yet", 32'(bus.apple_location), 32'h5555);
    tick;
    loc = bus.apple_location;
    chk("single_valid", 32'(bus.apple_valid), 32'h1);
    chk("single_not_head", 32'(loc[7:0] == 8'h00), 32'h0);
    bus.x = loc[3:0];
    bus.y = loc[7:4];
    #1;
    chk("single_hit", 32'(bus.apple), 32'h1);

    crowded(5'd2);
    pulse(2'b01);
    wait_idle("sweep_idle");
    publish;
    chk("sweep_loc", 32'(bus.apple_location), 32'h5533);
    chk("sweep_valid", 32'(bus.apple_valid), 32'h1);

    crowded(5'd3);
    pulse(2'b01);
    wait_idle("exhaust_idle");
    publish;
    chk("exhaust_valid", 32'(bus.apple_valid), 32'h0);
    bus.x = 4'd3;
    bus.y = 4'd3;
    #1;
    chk("exhaust_nohit", 32'(bus.apple), 32'h0);
    xmin = 4'd3;
    xmax = 4'd2;
    pulse(2'b01);
    wait_idle("inverted_idle");
    publish;
    chk("inverted_valid", 32'(bus.apple_valid), 32'h0);

    open_grid;
    enable_in = 1'b0;
    pulse(2'b11);
    wait_idle("gated_idle");
    publish;
    chk("gated_valid", 32'(bus.apple_valid), 32'h1);
    loc = bus.apple_location;
    chk("gated_loc1", 32'(loc[15:8]), 32'h0);
    enable_in = 1'b1;
    pulse(2'b10);
    wait_idle("enabled_idle");
    publish;
    loc = bus.apple_location;
    chk("enabled_valid", 32'(bus.apple_valid), 32'h3);
    chk("enabled_distinct", 32'(loc[15:8] == loc[7:0]), 32'h0);

    pulse(2'b11);
    wait_idle("both_idle");
    publish;
    loc = bus.apple_location;
    chk("both_valid", 32'(bus.apple_valid), 32'h3);
    chk("both_distinct", 32'(loc[15:8] == loc[7:0]), 32'h0);
    chk("both_not_head", 32'(loc[15:8] == 8'h00 || loc[7:0] == 8'h00), 32'h0);

    pulse(2'b01);
    tick;
    bus.good_collision = 2'b01;
    tick;
    bus.good_collision = 2'b00;
    chk("repulse_pending", 32'(bus.busy), 32'h1);
    wait_idle("repulse_idle");

    crowded(5'd3);
    pulse(2'b01);
    repeat (10) tick;
    chk("sweep_busy", 32'(bus.busy), 32'h1);
    nreset = 1'b0;
    #1;
    chk("midrst_loc", 32'(bus.apple_location), 32'h5555);
    chk("midrst_valid", 32'(bus.apple_valid), 32'h1);
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    tick;
    nreset = 1'b1;
    tick;
    chk("after_rst_busy", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
